// File: rtl/serial_alu.sv
// serial_alu: multi-cycle digit-serial ALU for the multi-cycle datapath.
// Processes DIGIT bits per RUN cycle, LSB digit first, with a
// start/busy/done handshake. Latency from accepted start to done is N+1.
// Optional feature: define SERIAL_ALU_XOR_EN to enable code 100 as XOR.
module serial_alu #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, shadow;
  logic [CW-1:0]      cnt;
  logic               carry;

  logic [DIGIT-1:0]   a_d, b_d, b_eff, res_d;
  logic [DIGIT:0]     sum;
  logic               sub_mode, ovf, slt_bit;
  logic [WIDTH-1:0]   final_res;

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start is honoured only in IDLE or DONE.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no
    // latch is inferred.
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        accept    = start;
        state_nxt = start ? RUN : IDLE;
      end
      RUN:     if (cnt == LAST) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // One digit of the datapath: adder slice, logic ops and SLT decision.
  always_comb begin
    a_d      = a_q[int'(cnt)*DIGIT +: DIGIT];
    b_d      = b_q[int'(cnt)*DIGIT +: DIGIT];
    sub_mode = (op_q == OP_SUB) || (op_q == OP_SLT);
    b_eff    = sub_mode ? ~b_d : b_d;
    sum      = {1'b0, a_d} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry};
    // Overflow: carry into the MSB differs from carry out of it.
    ovf      = (a_d[DIGIT-1] ^ b_eff[DIGIT-1] ^ sum[DIGIT-1]) ^ sum[DIGIT];
    slt_bit  = sum[DIGIT-1] ^ ovf;
    case (op_q)
      OP_ADD, OP_SUB: res_d = sum[DIGIT-1:0];
      OP_AND:         res_d = a_d & b_d;
      OP_OR:          res_d = a_d | b_d;
`ifdef SERIAL_ALU_XOR_EN
      OP_XOR:         res_d = a_d ^ b_d;
`endif
      default:        res_d = '0;
    endcase
    final_res = shadow;
    final_res[WIDTH-1 -: DIGIT] = res_d;
    if (op_q == OP_SLT) final_res = {{(WIDTH-1){1'b0}}, slt_bit};
  end

  // Operand capture, serial digit processing and result publication.
  always_ff @(posedge clk) begin
    // NOTE: the shadow register is reset with the rest of the datapath; it is
    // a flop array, not a RAM, so a reset costs nothing in inference.
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      shadow    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
    end else if (accept) begin
      op_q  <= ALUControl;
      a_q   <= SrcA;
      b_q   <= SrcB;
      cnt   <= '0;
      carry <= (ALUControl == OP_SUB) || (ALUControl == OP_SLT);
    end else if (state == RUN) begin
      shadow[int'(cnt)*DIGIT +: DIGIT] <= res_d;
      carry <= sum[DIGIT];
      if (cnt == LAST) begin
        cnt       <= '0;
        ALUResult <= final_res;
        Zero      <= (final_res == '0);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (WIDTH=32, DIGIT=8): directed cases
// plus randomized operations compared against an arithmetic reference.
module tb_serial_alu;

  localparam int WIDTH = 32;
  localparam int DIGIT = 8;
  localparam int N     = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] SrcA, SrcB;
  logic             busy, done, Zero;
  logic [WIDTH-1:0] ALUResult;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] last_res;

  serial_alu #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUControl(ALUControl),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
    .ALUResult(ALUResult), .Zero(Zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: plain arithmetic on whole words.
  function automatic logic [WIDTH-1:0] model(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a, b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 1 : 0;
`ifdef SERIAL_ALU_XOR_EN
      3'b100:  return a ^ b;
`endif
      default: return '0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues start in the current cycle and ends positioned in the DONE cycle.
  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [WIDTH-1:0] a, b, input bit repulse);
    logic [WIDTH-1:0] exp;
    exp = model(op, a, b);
    start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    step();
    start = 1'b0; SrcA = $urandom; SrcB = $urandom; ALUControl = 3'($urandom);
    for (int k = 1; k <= N; k++) begin
      check({tag, " busy"}, busy, 1);
      check({tag, " done early"}, done, 0);
      check({tag, " held result"}, ALUResult, last_res);
      if (repulse) begin
        start = 1'($urandom);
        SrcA  = $urandom;
      end
      step();
    end
    start = 1'b0;
    check({tag, " done"}, done, 1);
    check({tag, " busy at done"}, busy, 0);
    check({tag, " result"}, ALUResult, exp);
    check({tag, " zero"}, Zero, (exp == 0) ? 1 : 0);
    last_res = exp;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " idle done"}, done, 0);
    check({tag, " idle busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ALUControl = '0; SrcA = '0; SrcB = '0;
    last_res = '0;
    step(); step();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", ALUResult, 0);
    check("reset zero", Zero, 1);
    rst = 1'b0;
    step();

    // Directed cases from the plan; consecutive calls are back-to-back.
    do_op("add", 3'b000, 32'd5, 32'd7, 0);
    step(); check_idle("add");
    do_op("sub neg", 3'b001, 32'd3, 32'd5, 0);
    do_op("sub zero", 3'b001, 32'd9, 32'd9, 0);
    do_op("slt -1<1", 3'b101, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("slt ovf", 3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    do_op("slt min", 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 0);
    step(); check_idle("slt");
    do_op("and repulse", 3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 1);
    step(); check_idle("and single done");
    do_op("code100", 3'b100, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 0);
    do_op("code111", 3'b111, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 0);
    step();

    // Reset in the middle of an ADD: no done, reset values next cycle.
    start = 1'b1; ALUControl = 3'b000; SrcA = 32'd100; SrcB = 32'd200;
    step(); start = 1'b0;
    step();
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst result", ALUResult, 0);
    check("rst zero", Zero, 1);
    last_res = '0;
    for (int k = 0; k < N + 2; k++) begin
      check("rst no done", done, 0);
      step();
    end
    do_op("after rst", 3'b000, 32'd1, 32'd2, 0);
    step();

    // Randomized operations with corner-biased operands and random gaps.
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      logic [WIDTH-1:0] a, b;
      op = 3'($urandom);
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      do_op("random", op, a, b, 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        step(); check_idle("random");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
